interval_timer_scheduler: RTL and testbench

//  Avalon-MM master that owns one 16-bit-register interval timer and shares its periodic tick among NUM_CHAN requesters.
//  - Programs the timer period and control registers, then runs it in continuous mode with its interrupt enabled.
//  - On each timer irq, clears the timer status and decrements every armed channel's tick countdown.
//  - Pulses expired[ch] when a channel's countdown runs out.
//  - Sits between the timer slave and the hardware clients that need coarse timeouts.

---
 rtl/interval_timer_scheduler_pkg.sv | 29 ++
 rtl/tsched_chan.sv | 40 ++++
 rtl/interval_timer_scheduler.sv | 169 ++++++++++++++++
 tb/tb_interval_timer_scheduler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interval_timer_scheduler_pkg.sv
// rtl/interval_timer_scheduler_pkg.sv - FSM states, timer register map and control words for the scheduler
// TSCHED_RUN_CHECK_EN adds the post-clear status readback states.
package interval_timer_scheduler_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_PL,
    S_WR_PH,
    S_WR_CTL,
    S_RUN,
    S_CLR,
    S_SETTLE,
`ifdef TSCHED_RUN_CHECK_EN
    S_RD,
    S_RD_CHK,
`endif
    S_TICK,
    S_STOP
  } tsched_state_e;

  localparam logic [2:0] TM_STATUS  = 3'd0;
  localparam logic [2:0] TM_CONTROL = 3'd1;
  localparam logic [2:0] TM_PERIODL = 3'd2;
  localparam logic [2:0] TM_PERIODH = 3'd3;

  localparam logic [15:0] CTL_RUN  = 16'h0007;
  localparam logic [15:0] CTL_STOP = 16'h0008;

endpackage

// File: rtl/tsched_chan.sv
// rtl/tsched_chan.sv - one software-timer channel: 16-bit tick countdown, active flag, expiry pulse
module tsched_chan (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_load,
  input  logic [15:0] i_ticks,
  input  logic        i_tick,
  output logic        o_active,
  output logic        o_expired
);

  logic [15:0] r_count;
  logic        r_active;
  logic        r_expired;

  // Loading with zero ticks cancels the channel silently.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count   <= '0;
      r_active  <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_expired <= 1'b0;
      if (i_load) begin
        r_count  <= i_ticks;
        r_active <= (i_ticks != 16'd0);
      end else if (i_tick && r_active) begin
        if (r_count == 16'd1) begin
          r_active  <= 1'b0;
          r_expired <= 1'b1;
        end
        r_count <= r_count - 16'd1;
      end
    end
  end

  assign o_active  = r_active;
  assign o_expired = r_expired;

endmodule

// File: rtl/interval_timer_scheduler.sv
// rtl/interval_timer_scheduler.sv - Avalon-MM master running one interval timer and fanning its tick out to NUM_CHAN channels
// TSCHED_RUN_CHECK_EN: read status after each clear, flag o_fault and reprogram if the timer is not running.
module interval_timer_scheduler
  import interval_timer_scheduler_pkg::*;
#(
  parameter int          NUM_CHAN       = 4,
  parameter logic [31:0] DEFAULT_PERIOD = 32'h005F_5E0F,
  localparam int         CW             = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_enable,
  input  logic                i_period_wr,
  input  logic [31:0]         i_period_wdata,
  input  logic                i_arm_valid,
  output logic                o_arm_ready,
  input  logic [CW-1:0]       i_arm_chan,
  input  logic [15:0]         i_arm_ticks,
  output logic [NUM_CHAN-1:0] o_active,
  output logic [NUM_CHAN-1:0] o_expired,
  output logic [31:0]         o_tick_count,
  output logic                o_running,
`ifdef TSCHED_RUN_CHECK_EN
  output logic                o_fault,
`endif
  output logic [2:0]          o_tm_address,
  output logic                o_tm_chipselect,
  output logic                o_tm_write_n,
  output logic [15:0]         o_tm_writedata,
  input  logic [15:0]         i_tm_readdata,
  input  logic                i_tm_irq
);

  tsched_state_e r_state, w_state_nxt;
  logic [31:0]   r_pend_period;
  logic          r_pend;
  logic [15:0]   r_period_hi;
  logic [31:0]   r_tick_count;
  logic          r_rdy_en;
  logic          w_tick;
  logic          w_arm_fire;
  logic          w_unused_rd;

  assign w_unused_rd = ^i_tm_readdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_enable) w_state_nxt = S_WR_PL;
      S_WR_PL:  w_state_nxt = S_WR_PH;
      S_WR_PH:  w_state_nxt = S_WR_CTL;
      S_WR_CTL: w_state_nxt = S_RUN;
      S_RUN: begin
        if (i_tm_irq)       w_state_nxt = S_CLR;
        else if (r_pend)    w_state_nxt = S_WR_PL;
        else if (!i_enable) w_state_nxt = S_STOP;
      end
      S_CLR:    w_state_nxt = S_SETTLE;
`ifdef TSCHED_RUN_CHECK_EN
      S_SETTLE: w_state_nxt = S_RD;
      S_RD:     w_state_nxt = S_RD_CHK;
      S_RD_CHK: w_state_nxt = i_tm_readdata[1] ? S_TICK : S_WR_PL;
`else
      S_SETTLE: w_state_nxt = S_TICK;
`endif
      S_TICK:   w_state_nxt = S_RUN;
      S_STOP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_tm_address    = '0;
    o_tm_chipselect = 1'b0;
    o_tm_write_n    = 1'b1;
    o_tm_writedata  = '0;
    o_running       = 1'b0;
    w_tick          = 1'b0;
    case (r_state)
      S_WR_PL: begin
        o_tm_address = TM_PERIODL; o_tm_chipselect = 1'b1; o_tm_write_n = 1'b0;
        o_tm_writedata = r_pend_period[15:0];
      end
      S_WR_PH: begin
        o_tm_address = TM_PERIODH; o_tm_chipselect = 1'b1; o_tm_write_n = 1'b0;
        o_tm_writedata = r_period_hi;
      end
      S_WR_CTL: begin
        o_tm_address = TM_CONTROL; o_tm_chipselect = 1'b1; o_tm_write_n = 1'b0;
        o_tm_writedata = CTL_RUN;
      end
      S_RUN:    o_running = 1'b1;
      S_CLR: begin
        o_running = 1'b1;
        o_tm_address = TM_STATUS; o_tm_chipselect = 1'b1; o_tm_write_n = 1'b0;
      end
      S_SETTLE: o_running = 1'b1;
`ifdef TSCHED_RUN_CHECK_EN
      S_RD: begin
        o_running = 1'b1;
        o_tm_address = TM_STATUS; o_tm_chipselect = 1'b1;
      end
      S_RD_CHK: o_running = 1'b1;
`endif
      S_TICK: begin
        o_running = 1'b1;
        w_tick    = 1'b1;
      end
      S_STOP: begin
        o_tm_address = TM_CONTROL; o_tm_chipselect = 1'b1; o_tm_write_n = 1'b0;
        o_tm_writedata = CTL_STOP;
      end
      default: ;
    endcase
  end

  // The high half is captured with the low-half write so a period_wr landing mid-sequence
  // cannot tear the pair; it only re-raises the pend flag for another pass.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_period <= DEFAULT_PERIOD;
      r_pend        <= 1'b1;
      r_period_hi   <= '0;
      r_tick_count  <= '0;
      r_rdy_en      <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (i_period_wr) begin
        r_pend_period <= i_period_wdata;
        r_pend        <= 1'b1;
      end else if (r_state == S_WR_PL) begin
        r_pend <= 1'b0;
      end
      if (r_state == S_WR_PL) r_period_hi <= r_pend_period[31:16];
      if (w_tick)             r_tick_count <= r_tick_count + 32'd1;
    end
  end

`ifdef TSCHED_RUN_CHECK_EN
  logic r_fault;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                     r_fault <= 1'b0;
    else if (r_state == S_RD_CHK && !i_tm_readdata[1]) r_fault <= 1'b1;
  end
  assign o_fault = r_fault;
`endif

  assign o_arm_ready  = r_rdy_en && (r_state != S_TICK);
  assign w_arm_fire   = i_arm_valid && o_arm_ready;
  assign o_tick_count = r_tick_count;

  for (genvar g = 0; g < NUM_CHAN; g++) begin : g_chan
    tsched_chan u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_load    (w_arm_fire && (i_arm_chan == CW'(g))),
      .i_ticks   (i_arm_ticks),
      .i_tick    (w_tick),
      .o_active  (o_active[g]),
      .o_expired (o_expired[g])
    );
  end

endmodule

// File: tb/tb_interval_timer_scheduler.sv
// tb/tb_interval_timer_scheduler.sv - scoreboard bench with timer slave model and channel reference model
`timescale 1ns/1ps
module tb_interval_timer_scheduler;
  localparam int N = 4;
  localparam logic [31:0] DEF = 32'h005F_5E0F;
`ifdef TSCHED_RUN_CHECK_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;

  logic i_enable = 0, i_period_wr = 0, i_arm_valid = 0;
  logic [31:0] i_period_wdata = '0;
  logic [1:0]  i_arm_chan = '0;
  logic [15:0] i_arm_ticks = '0;
  logic o_arm_ready, o_running, o_tm_chipselect, o_tm_write_n;
  logic [N-1:0] o_active, o_expired;
  logic [31:0] o_tick_count;
  logic [2:0]  o_tm_address;
  logic [15:0] o_tm_writedata;
  logic [15:0] tm_readdata = '0;
  logic tm_irq = 1'b0;
`ifdef TSCHED_RUN_CHECK_EN
  logic o_fault;
`endif

  interval_timer_scheduler #(.NUM_CHAN(N), .DEFAULT_PERIOD(DEF)) dut (
    .clk(clk), .reset_n(reset_n), .i_enable(i_enable), .i_period_wr(i_period_wr),
    .i_period_wdata(i_period_wdata), .i_arm_valid(i_arm_valid), .o_arm_ready(o_arm_ready),
    .i_arm_chan(i_arm_chan), .i_arm_ticks(i_arm_ticks), .o_active(o_active),
    .o_expired(o_expired), .o_tick_count(o_tick_count), .o_running(o_running),
`ifdef TSCHED_RUN_CHECK_EN
    .o_fault(o_fault),
`endif
    .o_tm_address(o_tm_address), .o_tm_chipselect(o_tm_chipselect), .o_tm_write_n(o_tm_write_n),
    .o_tm_writedata(o_tm_writedata), .i_tm_readdata(tm_readdata), .i_tm_irq(tm_irq)
  );

  int n_checks = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Timer slave: period+1 clocks per timeout, registered irq and readdata.
  logic [15:0] t_pl, t_ph;
  logic [31:0] t_cnt;
  logic t_run, t_to, t_ito;
  bit inj_req = 0, inj_used = 0;
  always @(posedge clk) begin
    logic nto;
    if (!reset_n) begin
      t_pl <= '0; t_ph <= '0; t_cnt <= '0; t_run <= 0; t_to <= 0; t_ito <= 0; tm_irq <= 0;
    end else begin
      nto = t_to;
      if (t_run) begin
        if (t_cnt == 0) begin nto = 1'b1; t_cnt <= {t_ph, t_pl}; end
        else t_cnt <= t_cnt - 1;
      end
      if (o_tm_chipselect && !o_tm_write_n) begin
        case (o_tm_address)
          3'd0: nto = 1'b0;
          3'd1: begin
            t_ito <= o_tm_writedata[0];
            if (o_tm_writedata[2]) begin t_run <= 1; t_cnt <= {t_ph, t_pl}; end
            if (o_tm_writedata[3]) t_run <= 0;
          end
          3'd2: begin t_pl <= o_tm_writedata; t_run <= 0; end
          3'd3: begin t_ph <= o_tm_writedata; t_run <= 0; end
          default: ;
        endcase
      end
      if (o_tm_chipselect && o_tm_write_n) begin
        tm_readdata <= {14'd0, t_run, t_to};
        if (inj_req && !inj_used) begin tm_readdata[1] <= 1'b0; inj_used <= 1; end
      end
      t_to   <= nto;
      tm_irq <= nto & t_ito;
    end
  end

  // Reference model and scoreboard
  typedef struct { int ch; int tk; } exp_t;
  typedef struct { logic [2:0] a; logic [15:0] d; } wr_t;
  exp_t exp_q[$];
  wr_t  wr_q[$];
  bit   mon_en = 0;
  int   cyc = 0, tick_due = -1, fault_cyc = -1, m_ticks = 0;
  int   m_rem[N];
  bit   m_act[N];
  logic [31:0] m_period = DEF;

  task automatic push_prog(input logic [31:0] p);
    wr_q.push_back('{3'd2, p[15:0]});
    wr_q.push_back('{3'd3, p[31:16]});
    wr_q.push_back('{3'd1, 16'h0007});
  endtask

  always @(negedge clk) if (mon_en) begin
    bit is_tick;
    logic [N-1:0] act_exp;
    exp_t e;
    wr_t w;
    cyc++;
    is_tick = (tick_due == cyc);
    for (int i = 0; i < N; i++) act_exp[i] = m_act[i];
    chk("arm_ready", o_arm_ready, !is_tick);
    chk("active", o_active, act_exp);
    chk("tick_count", o_tick_count, m_ticks);
`ifdef TSCHED_RUN_CHECK_EN
    chk("fault", o_fault, (fault_cyc >= 0 && cyc >= fault_cyc));
`endif
    for (int i = 0; i < N; i++) if (o_expired[i]) begin
      chk("expired_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("expired_chan", i, e.ch);
        chk("expired_tick", o_tick_count, e.tk);
      end
    end
    if (o_tm_chipselect && !o_tm_write_n) begin
      if (o_tm_address == 3'd0) begin
        chk("clr_data", o_tm_writedata, 0);
        chk("clr_irq", tm_irq, 1);
        tick_due = cyc + LAT;
      end else begin
        chk("wr_expected", wr_q.size() > 0, 1);
        if (wr_q.size() > 0) begin
          w = wr_q.pop_front();
          chk("wr_addr", o_tm_address, w.a);
          chk("wr_data", o_tm_writedata, w.d);
        end
      end
    end
`ifdef TSCHED_RUN_CHECK_EN
    if (o_tm_chipselect && o_tm_write_n) begin
      chk("rd_addr", o_tm_address, 0);
      if (inj_req && !inj_used) begin
        tick_due  = -1;
        fault_cyc = cyc + 2;
        push_prog(m_period);
      end
    end
`endif
    if (i_arm_valid && !is_tick) begin
      m_act[i_arm_chan] = (i_arm_ticks != 0);
      m_rem[i_arm_chan] = i_arm_ticks;
    end
    if (is_tick) begin
      m_ticks++;
      for (int i = 0; i < N; i++) if (m_act[i]) begin
        if (m_rem[i] == 1) begin m_act[i] = 0; exp_q.push_back('{i, m_ticks}); end
        else m_rem[i]--;
      end
    end
  end

  task automatic arm(input int ch, input int t);
    i_arm_chan = ch[1:0]; i_arm_ticks = t[15:0]; i_arm_valid = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_arm_ready) break;
    end
    @(posedge clk); #1 i_arm_valid = 0;
  endtask

  task automatic period_write(input logic [31:0] p);
    push_prog(p);
    m_period = p;
    i_period_wr = 1; i_period_wdata = p;
    @(posedge clk); #1 i_period_wr = 0;
  endtask

  task automatic wait_wr(input int bound);
    for (int k = 0; k < bound; k++) begin
      if (wr_q.size() == 0) break;
      @(negedge clk);
    end
    chk("wr_drain", wr_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_running", o_running, 0);
    chk("rst_cs", o_tm_chipselect, 0);
    chk("rst_wn", o_tm_write_n, 1);
    chk("rst_addr", o_tm_address, 0);
    chk("rst_wdata", o_tm_writedata, 0);
    chk("rst_active", o_active, 0);
    chk("rst_expired", o_expired, 0);
    chk("rst_tick_count", o_tick_count, 0);
    chk("rst_arm_ready", o_arm_ready, 0);
`ifdef TSCHED_RUN_CHECK_EN
    chk("rst_fault", o_fault, 0);
`endif
    reset_n = 1;
    @(posedge clk); #1 mon_en = 1;

    push_prog(DEF);
    i_enable = 1;
    wait_wr(20);
    @(negedge clk);
    chk("bringup_running", o_running, 1);

    period_write(32'd9);
    wait_wr(20);
    arm(0, 3);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (o_expired[0]) break;
    end
    chk("ch0_expired", o_expired[0], 1);
    chk("ch0_tick_count", o_tick_count, 3);

    arm(1, 5);
    arm(1, 0);
    chk("ch1_cancel", o_active[1], 0);
    arm(2, 1);
    repeat (30) @(posedge clk);
    #1;

    push_prog(32'd4);
    i_period_wr = 1; i_period_wdata = 32'd19;
    @(posedge clk); #1 i_period_wdata = 32'd4; m_period = 32'd4;
    @(posedge clk); #1 i_period_wr = 0;
    wait_wr(40);
    repeat (20) @(posedge clk);
    #1;
    period_write(32'd9);
    wait_wr(40);

    repeat (60) begin
      repeat ($urandom_range(0, 6)) @(posedge clk);
      #1;
      arm($urandom_range(0, N - 1), $urandom_range(0, 4));
    end

`ifdef TSCHED_RUN_CHECK_EN
    inj_req = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (o_fault) break;
    end
    chk("fault_set", o_fault, 1);
    wait_wr(40);
    t0 = o_tick_count;
    repeat (15) begin
      repeat ($urandom_range(0, 6)) @(posedge clk);
      #1;
      arm($urandom_range(0, N - 1), $urandom_range(1, 3));
    end
    chk("ticks_resume", o_tick_count > t0, 1);
`else
    t0 = 0;
`endif

    wr_q.push_back('{3'd1, 16'h0008});
    i_enable = 0;
    wait_wr(60);
    repeat (2) @(negedge clk);
    chk("stop_running", o_running, 0);
    repeat (5) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
